// File: rtl/morse_code_decoder.sv
// Decodes a hand-keyed Morse input into ASCII: measures mark/space lengths in
// dit units, assembles dit/dah elements, and strobes one byte per character or word gap.
module morse_code_decoder #(
  parameter int DIT_CYCLES     = 1_200_000,
  parameter int DAH_UNITS      = 2,
  parameter int CHAR_GAP_UNITS = 2,
  parameter int WORD_GAP_UNITS = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       morse_in,
  output logic [7:0] char_data,
  output logic       char_valid,
  output logic       key_active
);

  localparam int PW = (DIT_CYCLES > 2) ? $clog2(DIT_CYCLES) : 1;
  localparam logic [PW-1:0] PRE_MAX   = PW'(DIT_CYCLES - 1);
  localparam logic [2:0]    DAH_U     = 3'(DAH_UNITS);
  localparam logic [2:0]    CHAR_GAP  = 3'(CHAR_GAP_UNITS);
  localparam logic [2:0]    WORD_GAP  = 3'(WORD_GAP_UNITS);

  typedef enum logic [1:0] {IDLE, MARK, GAP, WORD_WAIT} state_t;

  state_t          state;
  logic            sync1, key_s, key_q;
  logic [PW-1:0]   prescaler;
  logic [2:0]      units;
  logic [5:0]      code;
  logic [2:0]      len;
  logic            ovf;
  logic            rise, fall;

  assign rise       = key_s & ~key_q;
  assign fall       = ~key_s & key_q;
  assign key_active = key_s;

  // Matches the full code register; bits above len are always zero because
  // the register is cleared whenever a character is emitted.
  function automatic logic [7:0] lookup(input logic [5:0] c, input logic [2:0] n,
                                        input logic o);
    logic [7:0] ch;
    ch = "?";
    case ({n, c})
      {3'd1, 6'b000000}: ch = "E";
      {3'd1, 6'b000001}: ch = "T";
      {3'd2, 6'b000000}: ch = "I";
      {3'd2, 6'b000001}: ch = "A";
      {3'd2, 6'b000010}: ch = "N";
      {3'd2, 6'b000011}: ch = "M";
      {3'd3, 6'b000000}: ch = "S";
      {3'd3, 6'b000001}: ch = "U";
      {3'd3, 6'b000010}: ch = "R";
      {3'd3, 6'b000011}: ch = "W";
      {3'd3, 6'b000100}: ch = "D";
      {3'd3, 6'b000101}: ch = "K";
      {3'd3, 6'b000110}: ch = "G";
      {3'd3, 6'b000111}: ch = "O";
      {3'd4, 6'b000000}: ch = "H";
      {3'd4, 6'b000001}: ch = "V";
      {3'd4, 6'b000010}: ch = "F";
      {3'd4, 6'b000100}: ch = "L";
      {3'd4, 6'b000110}: ch = "P";
      {3'd4, 6'b000111}: ch = "J";
      {3'd4, 6'b001000}: ch = "B";
      {3'd4, 6'b001001}: ch = "X";
      {3'd4, 6'b001010}: ch = "C";
      {3'd4, 6'b001011}: ch = "Y";
      {3'd4, 6'b001100}: ch = "Z";
      {3'd4, 6'b001101}: ch = "Q";
      {3'd5, 6'b011111}: ch = "0";
      {3'd5, 6'b001111}: ch = "1";
      {3'd5, 6'b000111}: ch = "2";
      {3'd5, 6'b000011}: ch = "3";
      {3'd5, 6'b000001}: ch = "4";
      {3'd5, 6'b000000}: ch = "5";
      {3'd5, 6'b010000}: ch = "6";
      {3'd5, 6'b011000}: ch = "7";
      {3'd5, 6'b011100}: ch = "8";
      {3'd5, 6'b011110}: ch = "9";
      default:           ch = "?";
    endcase
    if (o) ch = "?";
    return ch;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      key_s <= 1'b0;
      key_q <= 1'b0;
    end else begin
      sync1 <= morse_in;
      key_s <= sync1;
      key_q <= key_s;
    end
  end

  // The edge cycle itself is tick 0 of the new interval, so the prescaler
  // restarts at 1 and units reads whole elapsed units at the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler <= '0;
      units     <= '0;
    end else if (rise || fall) begin
      prescaler <= PW'(1);
      units     <= '0;
    end else if (prescaler == PRE_MAX) begin
      prescaler <= '0;
      if (units != 3'd7) units <= units + 3'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      code       <= '0;
      len        <= '0;
      ovf        <= 1'b0;
      char_data  <= 8'h00;
      char_valid <= 1'b0;
    end else begin
      char_valid <= 1'b0;
      case (state)
        IDLE: if (rise) state <= MARK;
        MARK: begin
          if (fall) begin
            if (len == 3'd6) begin
              ovf <= 1'b1;
            end else begin
              code <= {code[4:0], (units >= DAH_U)};
              len  <= len + 3'd1;
            end
            state <= GAP;
          end
        end
        GAP: begin
          if (rise) begin
            state <= MARK;
          end else if (units == CHAR_GAP) begin
            char_data  <= lookup(code, len, ovf);
            char_valid <= 1'b1;
            code       <= '0;
            len        <= '0;
            ovf        <= 1'b0;
            state      <= WORD_WAIT;
          end
        end
        WORD_WAIT: begin
          if (rise) begin
            state <= MARK;
          end else if (units == WORD_GAP) begin
            char_data  <= 8'h20;
            char_valid <= 1'b1;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_morse_code_decoder.sv
// Directed bench for morse_code_decoder at 4 clocks per dit: every strobe is
// recorded and compared against hand-decoded characters and word spaces.
module tb_morse_code_decoder;

  logic       clk;
  logic       rst_n;
  logic       morse_in;
  logic [7:0] char_data;
  logic       char_valid;
  logic       key_active;

  int         compared;
  int         mismatched;
  logic [7:0] strobe_q[$];
  int         base;

  morse_code_decoder #(
    .DIT_CYCLES(4), .DAH_UNITS(2), .CHAR_GAP_UNITS(2), .WORD_GAP_UNITS(5)
  ) dut (
    .clk(clk), .rst_n(rst_n), .morse_in(morse_in),
    .char_data(char_data), .char_valid(char_valid), .key_active(key_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records every strobed byte in emission order.
  always @(posedge clk) begin
    if (char_valid === 1'b1) strobe_q.push_back(char_data);
  end

  task automatic applyStimulus(input logic level, input int cycles);
    morse_in = level;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Expects exactly two new strobes since idx: the character then a word space.
  task automatic checkChar(input string tag, input int idx, input logic [7:0] ch);
    checkOutput({tag, "_count"}, 32'(strobe_q.size() - idx), 32'd2);
    if (strobe_q.size() >= idx + 2) begin
      checkOutput({tag, "_char"}, {24'd0, strobe_q[idx]}, {24'd0, ch});
      checkOutput({tag, "_space"}, {24'd0, strobe_q[idx+1]}, 32'h20);
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst_n      = 1'b0;
    morse_in   = 1'b0;

    for (int i = 0; i < 6; i++) applyStimulus(i[0], 2);
    checkOutput("reset_char_data", {24'd0, char_data}, 32'h00);
    checkOutput("reset_char_valid", {31'd0, char_valid}, 32'd0);
    checkOutput("reset_key_active", {31'd0, key_active}, 32'd0);
    morse_in = 1'b0;
    rst_n    = 1'b1;
    repeat (100) @(negedge clk);
    checkOutput("idle_no_strobe", 32'(strobe_q.size()), 32'd0);

    // Letter A with exact strobe timing relative to the final release.
    base = strobe_q.size();
    applyStimulus(1'b1, 3);
    checkOutput("key_active_mark", {31'd0, key_active}, 32'd1);
    applyStimulus(1'b1, 1);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 10);
    checkOutput("a_valid_early", {31'd0, char_valid}, 32'd0);
    @(negedge clk);
    checkOutput("a_valid", {31'd0, char_valid}, 32'd1);
    checkOutput("a_data", {24'd0, char_data}, 32'h41);
    @(negedge clk);
    checkOutput("a_valid_one_cycle", {31'd0, char_valid}, 32'd0);
    repeat (11) @(negedge clk);
    checkOutput("space_valid", {31'd0, char_valid}, 32'd1);
    checkOutput("space_data", {24'd0, char_data}, 32'h20);
    repeat (40) @(negedge clk);
    checkChar("letter_a", base, 8'h41);
    checkOutput("data_held", {24'd0, char_data}, 32'h20);

    // Five dahs of exactly two units each: digit zero.
    base = strobe_q.size();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8);
      applyStimulus(1'b0, (i == 4) ? 30 : 4);
    end
    checkChar("digit_0", base, 8'h30);

    // A 7-clock mark is one unit: still a dit.
    base = strobe_q.size();
    applyStimulus(1'b1, 7);
    applyStimulus(1'b0, 30);
    checkChar("letter_e", base, 8'h45);

    // Seven dits overflow the symbol register.
    base = strobe_q.size();
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, (i == 6) ? 30 : 4);
    end
    checkChar("overflow", base, 8'h3F);

    base = strobe_q.size();
    applyStimulus(1'b1, 12);
    applyStimulus(1'b0, 30);
    checkChar("after_ovf_t", base, 8'h54);

    // Rise lands on the character-gap threshold cycle: elements merge.
    base = strobe_q.size();
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 8);
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 30);
    checkChar("collision_i", base, 8'h49);

    // Reset pulse with the key held down partway through ".-".
    base = strobe_q.size();
    applyStimulus(1'b1, 4);
    applyStimulus(1'b0, 4);
    applyStimulus(1'b1, 12);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n    = 1'b1;
    morse_in = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("midreset_no_strobe", 32'(strobe_q.size() - base), 32'd0);
    checkOutput("midreset_data", {24'd0, char_data}, 32'h00);
    checkOutput("midreset_key", {31'd0, key_active}, 32'd0);

    base = strobe_q.size();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4);
      applyStimulus(1'b0, (i == 2) ? 30 : 4);
    end
    checkChar("letter_s", base, 8'h53);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
